// File: rtl/gpr_write_arbiter_pkg.sv
// Shared types for the GPR write-port arbiter: register/data vectors and the
// write-request record that travels through the result buffer and the port mux.
package gpr_write_arbiter_pkg;

    typedef logic [4:0]  Vec5;
    typedef logic [31:0] Vec32;

    typedef struct packed {
        logic valid;
        Vec5  dst;
        Vec32 data;
    } GprWriteReq;

    localparam GprWriteReq GPR_WRITE_IDLE = '0;

    // Writes to $0 are architecturally meaningless and never reach the file.
    function automatic logic eff_write(input logic valid, input Vec5 dst);
        return valid && (dst != 5'd0);
    endfunction

endpackage

// File: rtl/gpr_write_arbiter_if.sv
// Signal bundle between the pipeline (WriteBack, long-latency unit, decode)
// and the GPR write arbiter; the arbiter uses the slave view.
interface gpr_write_arbiter_if;
    import gpr_write_arbiter_pkg::*;

    logic wb_valid;
    Vec5  wb_reg;
    Vec32 wb_data;
    logic lu_valid;
    Vec5  lu_reg;
    Vec32 lu_data;
    logic lu_ready;
    logic gpr_we;
    Vec5  gpr_waddr;
    Vec32 gpr_wdata;
    Vec5  rs_query;
    Vec5  rt_query;
    logic rs_pending;
    logic rt_pending;
    logic pend_busy;
    logic stall_req;

    modport slave (
        input  wb_valid, wb_reg, wb_data, lu_valid, lu_reg, lu_data, rs_query, rt_query,
        output lu_ready, gpr_we, gpr_waddr, gpr_wdata, rs_pending, rt_pending, pend_busy, stall_req
    );

    modport master (
        output wb_valid, wb_reg, wb_data, lu_valid, lu_reg, lu_data, rs_query, rt_query,
        input  lu_ready, gpr_we, gpr_waddr, gpr_wdata, rs_pending, rt_pending, pend_busy, stall_req
    );

endinterface

// File: rtl/gpr_write_arbiter_fifo.sv
// Circular buffer of long-latency results with per-entry WAW kill and a
// parallel destination match used by the decode scoreboard.
module gpr_wr_fifo
    import gpr_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_enq,
    input  Vec5        i_enq_reg,
    input  Vec32       i_enq_data,
    input  logic       i_deq,
    input  logic       i_kill,
    input  Vec5        i_kill_reg,
    input  Vec5        i_rs_query,
    input  Vec5        i_rt_query,
    output GprWriteReq o_head,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_rs_match,
    output logic       o_rt_match
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    Vec5             r_reg  [DEPTH];
    Vec32            r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [DEPTH-1:0] w_live_next;
    logic [DEPTH-1:0] w_rs_hit;
    logic [DEPTH-1:0] w_rt_hit;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    // A live bit means "occupied and not killed", so slots outside the
    // head..tail window can never produce a scoreboard hit.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_live_next[gi] =
                (i_enq && r_tail == PW'(gi)) ? 1'b1 :
                (i_deq && r_head == PW'(gi)) ? 1'b0 :
                (i_kill && r_reg[gi] == i_kill_reg) ? 1'b0 : r_live[gi];
            assign w_rs_hit[gi] = r_live[gi] && (r_reg[gi] == i_rs_query);
            assign w_rt_hit[gi] = r_live[gi] && (r_reg[gi] == i_rt_query);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_live  <= '0;
        end else begin
            r_live <= w_live_next;
            if (i_enq) r_tail <= r_tail + 1'b1;
            if (i_deq) r_head <= r_head + 1'b1;
            case ({i_enq, i_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (i_enq) begin
            r_reg[r_tail]  <= i_enq_reg;
            r_data[r_tail] <= i_enq_data;
        end
    end

    assign o_head     = '{valid: r_live[r_head], dst: r_reg[r_head], data: r_data[r_head]};
    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == '0);
    assign o_rs_match = (i_rs_query != 5'd0) && (|w_rs_hit);
    assign o_rt_match = (i_rt_query != 5'd0) && (|w_rt_hit);

endmodule

// File: rtl/gpr_write_arbiter.sv
// Shares the register-file write port between WriteBack (always wins) and a
// buffered long-latency unit; also drives the pending scoreboard and bubble request.
module gpr_write_arbiter
    import gpr_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clock,
    input logic           reset,
    gpr_write_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic       w_full;
    logic       w_empty;
    logic       w_rs_match;
    logic       w_rt_match;
    GprWriteReq w_head;
    GprWriteReq w_port;
    logic       w_wb_eff;
    logic       w_lu_ready;
    logic       w_lu_keep;
    logic       w_bypass;
    logic       w_enq;
    logic       w_deq;
    logic       w_kill;
    logic [SW-1:0] r_starve_cnt;

    assign w_wb_eff   = eff_write(bus.wb_valid, bus.wb_reg);
    assign w_lu_ready = reset && !w_full;
    // A result aimed at $0, or at the register WriteBack overwrites now, is stale on arrival.
    assign w_lu_keep  = bus.lu_valid && w_lu_ready && (bus.lu_reg != 5'd0)
                        && !(w_wb_eff && bus.lu_reg == bus.wb_reg);
    assign w_bypass   = w_lu_keep && !w_wb_eff && w_empty;
    assign w_enq      = w_lu_keep && !w_bypass;
    assign w_deq      = reset && !w_wb_eff && !w_empty;
    assign w_kill     = reset && w_wb_eff;

    gpr_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_enq      (w_enq),
        .i_enq_reg  (bus.lu_reg),
        .i_enq_data (bus.lu_data),
        .i_deq      (w_deq),
        .i_kill     (w_kill),
        .i_kill_reg (bus.wb_reg),
        .i_rs_query (bus.rs_query),
        .i_rt_query (bus.rt_query),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_rs_match (w_rs_match),
        .o_rt_match (w_rt_match)
    );

    // A killed head still takes the port for one cycle, but writes nothing.
    always_comb begin
        w_port = GPR_WRITE_IDLE;
        if (!reset) begin
            w_port = GPR_WRITE_IDLE;
        end else if (w_wb_eff) begin
            w_port = '{valid: 1'b1, dst: bus.wb_reg, data: bus.wb_data};
        end else if (!w_empty) begin
            if (w_head.valid) w_port = w_head;
        end else if (w_bypass) begin
            w_port = '{valid: 1'b1, dst: bus.lu_reg, data: bus.lu_data};
        end
    end

    // Non-empty without a dequeue can only mean WriteBack held the port.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_deq || w_empty) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign bus.lu_ready   = w_lu_ready;
    assign bus.gpr_we     = w_port.valid;
    assign bus.gpr_waddr  = w_port.dst;
    assign bus.gpr_wdata  = w_port.data;
    assign bus.rs_pending = reset && w_rs_match;
    assign bus.rt_pending = reset && w_rt_match;
    assign bus.pend_busy  = reset && !w_empty;
    assign bus.stall_req  = reset && (r_starve_cnt == STARVE_MAX);

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Directed bench for gpr_write_arbiter: a per-cycle vector table plus
// hand-written starvation and mid-operation reset sequences.
module tb_gpr_write_arbiter;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    gpr_write_arbiter_if bus();

    gpr_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Register-file model and a tally of writes to the registers that must never land.
    logic [31:0] rf [32];
    int          forbidden_writes = 0;
    always @(posedge clock) begin
        if (bus.gpr_we) begin
            rf[bus.gpr_waddr] <= bus.gpr_wdata;
            if (bus.gpr_waddr == 5'd13 || bus.gpr_waddr == 5'd14)
                forbidden_writes <= forbidden_writes + 1;
        end
    end

    typedef struct {
        string       name;
        logic        rst;
        logic        wv;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] ld;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_rsp;
        logic        e_rtp;
        logic        e_busy;
        logic        e_stall;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string n, bit rst, bit wv, int wr, int wd, bit lv, int lr, int ld,
                                int rs, int rt, bit rdy, bit we, int wa, int wdat,
                                bit rsp, bit rtp, bit busy, bit stl);
        vec_t v;
        v.name = n; v.rst = rst; v.wv = wv; v.wr = 5'(wr); v.wd = 32'(wd);
        v.lv = lv; v.lr = 5'(lr); v.ld = 32'(ld); v.rs = 5'(rs); v.rt = 5'(rt);
        v.e_rdy = rdy; v.e_we = we; v.e_wa = 5'(wa); v.e_wd = 32'(wdat);
        v.e_rsp = rsp; v.e_rtp = rtp; v.e_busy = busy; v.e_stall = stl;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(bit rst, bit wv, logic [4:0] wr, logic [31:0] wd,
                         bit lv, logic [4:0] lr, logic [31:0] ld, logic [4:0] rs, logic [4:0] rt);
        reset        = rst;
        bus.wb_valid = wv;
        bus.wb_reg   = wr;
        bus.wb_data  = wd;
        bus.lu_valid = lv;
        bus.lu_reg   = lr;
        bus.lu_data  = ld;
        bus.rs_query = rs;
        bus.rt_query = rt;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //          name        rst wv wr wd       lv lr ld       rs rt  rdy we wa wdata   rsp rtp busy stl
        vq.push_back(mk("rst0",   0, 1, 3, 'h33,   1, 8, 'h1234, 0, 0,  0, 0, 0, 0,       0, 0, 0, 0));
        vq.push_back(mk("rst1",   0, 1, 3, 'h33,   1, 8, 'h1234, 0, 0,  0, 0, 0, 0,       0, 0, 0, 0));
        vq.push_back(mk("bypass", 1, 0, 0, 0,      1, 8, 'h1234, 8, 0,  1, 1, 8, 'h1234,  0, 0, 0, 0));
        vq.push_back(mk("cont1",  1, 1, 1, 'h11,   1, 9, 'h99,   9, 10, 1, 1, 1, 'h11,    0, 0, 0, 0));
        vq.push_back(mk("cont2",  1, 1, 2, 'h22,   1, 10, 'hA0,  9, 10, 1, 1, 2, 'h22,    1, 0, 1, 0));
        vq.push_back(mk("cont3",  1, 1, 3, 'h33,   1, 11, 'hB0,  9, 10, 0, 1, 3, 'h33,    1, 1, 1, 0));
        vq.push_back(mk("drain9", 1, 0, 0, 0,      0, 0, 0,      9, 10, 0, 1, 9, 'h99,    1, 1, 1, 0));
        vq.push_back(mk("drain10",1, 0, 0, 0,      0, 0, 0,      9, 10, 1, 1, 10, 'hA0,   0, 1, 1, 0));
        vq.push_back(mk("idle1",  1, 0, 0, 0,      0, 0, 0,      9, 10, 1, 0, 0, 0,       0, 0, 0, 0));
        vq.push_back(mk("buf5",   1, 1, 4, 'h44,   1, 5, 'hAAAA, 5, 0,  1, 1, 4, 'h44,    0, 0, 0, 0));
        vq.push_back(mk("kill5",  1, 1, 5, 'hBBBB, 0, 0, 0,      5, 0,  1, 1, 5, 'hBBBB,  1, 0, 1, 0));
        vq.push_back(mk("deqdead",1, 0, 0, 0,      0, 0, 0,      5, 0,  1, 0, 0, 0,       0, 0, 1, 0));
        vq.push_back(mk("idle2",  1, 0, 0, 0,      0, 0, 0,      5, 0,  1, 0, 0, 0,       0, 0, 0, 0));
        vq.push_back(mk("zero",   1, 1, 0, 'hDEAD, 1, 0, 'hBEEF, 0, 0,  1, 0, 0, 0,       0, 0, 0, 0));
        vq.push_back(mk("zeroaft",1, 0, 0, 0,      0, 0, 0,      0, 0,  1, 0, 0, 0,       0, 0, 0, 0));
        vq.push_back(mk("samereg",1, 1, 7, 'h77,   1, 7, 'h70,   7, 0,  1, 1, 7, 'h77,    0, 0, 0, 0));
        vq.push_back(mk("sameaft",1, 0, 0, 0,      0, 0, 0,      7, 0,  1, 0, 0, 0,       0, 0, 0, 0));

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].wv, vq[i].wr, vq[i].wd, vq[i].lv, vq[i].lr, vq[i].ld,
                  vq[i].rs, vq[i].rt);
            @(negedge clock);
            $display("vec %0d %s we=%0b waddr=%0d wdata=%h rdy=%0b busy=%0b stall=%0b rsp=%0b rtp=%0b",
                     i, vq[i].name, bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.lu_ready,
                     bus.pend_busy, bus.stall_req, bus.rs_pending, bus.rt_pending);
            chk({vq[i].name, ".lu_ready"},   32'(bus.lu_ready),   32'(vq[i].e_rdy));
            chk({vq[i].name, ".gpr_we"},     32'(bus.gpr_we),     32'(vq[i].e_we));
            chk({vq[i].name, ".gpr_waddr"},  32'(bus.gpr_waddr),  32'(vq[i].e_wa));
            chk({vq[i].name, ".gpr_wdata"},  bus.gpr_wdata,       vq[i].e_wd);
            chk({vq[i].name, ".rs_pending"}, 32'(bus.rs_pending), 32'(vq[i].e_rsp));
            chk({vq[i].name, ".rt_pending"}, 32'(bus.rt_pending), 32'(vq[i].e_rtp));
            chk({vq[i].name, ".pend_busy"},  32'(bus.pend_busy),  32'(vq[i].e_busy));
            chk({vq[i].name, ".stall_req"},  32'(bus.stall_req),  32'(vq[i].e_stall));
            tick();
        end
        chk("waw.rf5", rf[5], 32'hBBBB);

        // Starvation: one buffered entry while WriteBack writes every cycle.
        drive(1, 1, 5'd1, 32'h1, 1, 5'd6, 32'h66, 0, 0);
        tick();
        for (int c = 1; c <= 6; c++) begin
            drive(1, 1, 5'd1, 32'(c), 0, 0, 0, 0, 0);
            @(negedge clock);
            $display("starve cycle %0d we=%0b waddr=%0d stall=%0b busy=%0b",
                     c, bus.gpr_we, bus.gpr_waddr, bus.stall_req, bus.pend_busy);
            chk($sformatf("starve.c%0d.stall", c), 32'(bus.stall_req), (c >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("starve.c%0d.waddr", c), 32'(bus.gpr_waddr), 32'd1);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        $display("starve release we=%0b waddr=%0d wdata=%h stall=%0b",
                 bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.stall_req);
        chk("starve.rel.stall", 32'(bus.stall_req), 32'd1);
        chk("starve.rel.we",    32'(bus.gpr_we),    32'd1);
        chk("starve.rel.waddr", 32'(bus.gpr_waddr), 32'd6);
        chk("starve.rel.wdata", bus.gpr_wdata,      32'h66);
        tick();
        @(negedge clock);
        $display("starve after stall=%0b busy=%0b", bus.stall_req, bus.pend_busy);
        chk("starve.after.stall", 32'(bus.stall_req), 32'd0);
        chk("starve.after.busy",  32'(bus.pend_busy), 32'd0);
        tick();

        // Mid-operation reset: fill both slots, then reset and confirm nothing drains.
        drive(1, 1, 5'd2, 32'h2, 1, 5'd13, 32'hD0, 0, 0);
        tick();
        drive(1, 1, 5'd3, 32'h3, 1, 5'd14, 32'hE0, 13, 14);
        tick();
        drive(1, 1, 5'd4, 32'h4, 0, 0, 0, 13, 14);
        @(negedge clock);
        $display("full we=%0b rdy=%0b busy=%0b rsp=%0b rtp=%0b",
                 bus.gpr_we, bus.lu_ready, bus.pend_busy, bus.rs_pending, bus.rt_pending);
        chk("full.lu_ready", 32'(bus.lu_ready),   32'd0);
        chk("full.busy",     32'(bus.pend_busy),  32'd1);
        chk("full.rt_pend",  32'(bus.rt_pending), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 13, 14);
        @(negedge clock);
        $display("midrst we=%0b rdy=%0b busy=%0b rsp=%0b", bus.gpr_we, bus.lu_ready, bus.pend_busy, bus.rs_pending);
        chk("midrst.we",      32'(bus.gpr_we),     32'd0);
        chk("midrst.ready",   32'(bus.lu_ready),   32'd0);
        chk("midrst.rs_pend", 32'(bus.rs_pending), 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 13, 14);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            $display("postrst %0d we=%0b rdy=%0b busy=%0b", c, bus.gpr_we, bus.lu_ready, bus.pend_busy);
            chk($sformatf("postrst%0d.we", c),    32'(bus.gpr_we),    32'd0);
            chk($sformatf("postrst%0d.busy", c),  32'(bus.pend_busy), 32'd0);
            chk($sformatf("postrst%0d.ready", c), 32'(bus.lu_ready),  32'd1);
            tick();
        end
        chk("midrst.no_write", 32'(forbidden_writes), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
